iig_ctrl: RTL

Controller and sequencer for integral-image generation over one detection window of WIN_W x WIN_H 8-bit pixels.
- Accepts a raster-ordered pixel stream.
- Drives a per-row accumulator (clear and enable).
- Adds each running row sum to the previous row's integral value held in a line buffer.
- Emits the integral value for each pixel.
It sits between the pixel fetch stage and the integral-image store that feeds the cascade classifier.

---
 rtl/iig_pkg.sv | 26 ++
 rtl/iig_line_buf.sv | 28 ++
 rtl/iig_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/iig_pkg.sv
// Shared types and defaults for the integral-image controller.
// The squared-integral path is enabled by defining IIG_SQ_EN.
package iig_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    ROW_END = 3'd3,
    DONE    = 3'd4
  } iigState_e;

  localparam int WIN_W_DEF = 24;
  localparam int WIN_H_DEF = 24;
  localparam int DW_DEF    = 21;
  localparam int CW_DEF    = 6;
  localparam int SQW_DEF   = 26;

  // True when maxVal*w*h (largest possible integral) fits in 'bits' unsigned bits
  function automatic bit iigFits(input int w, input int h, input int maxVal, input int bits);
    longint peak;
    peak = longint'(maxVal) * longint'(w) * longint'(h);
    return (bits >= 63) || (peak < (64'sd1 << bits));
  endfunction

endpackage

// File: rtl/iig_line_buf.sv
// One-row line buffer: WIN_W entries, combinational read, synchronous write.
// Contents are deliberately not reset; the controller masks them on the first row.
module iig_line_buf
  import iig_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = 5
) (
  input  logic          iClk,
  input  logic          iWe,
  input  logic [AW-1:0] iAddr,
  input  logic [DW-1:0] iWData,
  output logic [DW-1:0] oRData
);

  logic [DW-1:0] mem_r [WIN_W];

  assign oRData = mem_r[iAddr];

  // write port; read above returns the pre-write value in the same cycle
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_r[iAddr] <= iWData;
    end
  end

endmodule

// File: rtl/iig_ctrl.sv
// Integral-image sequencer for one WIN_W x WIN_H window of 8-bit pixels.
// Define IIG_SQ_EN to add the squared-pixel integral output oSqData.
module iig_ctrl
  import iig_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int WIN_H = WIN_H_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF
`ifdef IIG_SQ_EN
  ,
  parameter int SQW   = SQW_DEF
`endif
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iStart,
  input  logic          iAbort,
  input  logic          iValid,
  input  logic [7:0]    iData,
  output logic          oReady,
  output logic          oValid,
  output logic [DW-1:0] oData,
  output logic [CW-1:0] oRow,
  output logic [CW-1:0] oCol,
  output logic          oBusy,
  output logic          oDone
`ifdef IIG_SQ_EN
  ,
  output logic [SQW-1:0] oSqData
`endif
);

  localparam int LBAW = (WIN_W > 1) ? $clog2(WIN_W) : 1;

  if (!iigFits(WIN_W, WIN_H, 255, DW)) begin : gDwCheck
    $error("iig_ctrl: DW too narrow for the window integral");
  end
  if (((32'sd1 << CW) < WIN_W) || ((32'sd1 << CW) < WIN_H)) begin : gCwCheck
    $error("iig_ctrl: CW too narrow for the window dimensions");
  end

  iigState_e     state_r;
  logic [DW-1:0] rowAcc_r;
  logic [CW-1:0] col_r;
  logic [CW-1:0] row_r;
  logic          firstRow_r;

  logic            accept_s;
  logic [DW-1:0]   rowSum_s;
  logic [DW-1:0]   lbRData_s;
  logic [DW-1:0]   integ_s;
  logic [LBAW-1:0] lbAddr_s;

`ifdef IIG_SQ_EN
  if (!iigFits(WIN_W, WIN_H, 65025, SQW)) begin : gSqwCheck
    $error("iig_ctrl: SQW too narrow for the squared integral");
  end

  logic [SQW-1:0] sqAcc_r;
  logic [15:0]    pixSq_s;
  logic [SQW-1:0] sqSum_s;
  logic [SQW-1:0] sqRData_s;
  logic [SQW-1:0] sqInteg_s;
`endif

  assign lbAddr_s = col_r[LBAW-1:0];

  // acceptance and integral arithmetic; the line buffer is ignored on the first row
  always_comb begin
    accept_s = (state_r == RUN) && iValid && !iAbort;
    rowSum_s = rowAcc_r + DW'(iData);
    if (firstRow_r) begin
      integ_s = rowSum_s;
    end else begin
      integ_s = rowSum_s + lbRData_s;
    end
`ifdef IIG_SQ_EN
    pixSq_s = {8'd0, iData} * {8'd0, iData};
    sqSum_s = sqAcc_r + SQW'(pixSq_s);
    if (firstRow_r) begin
      sqInteg_s = sqSum_s;
    end else begin
      sqInteg_s = sqSum_s + sqRData_s;
    end
`endif
  end

  iig_line_buf #(.WIN_W(WIN_W), .DW(DW), .AW(LBAW)) uLineBuf (
    .iClk   (iClk),
    .iWe    (accept_s),
    .iAddr  (lbAddr_s),
    .iWData (integ_s),
    .oRData (lbRData_s)
  );

`ifdef IIG_SQ_EN
  iig_line_buf #(.WIN_W(WIN_W), .DW(SQW), .AW(LBAW)) uSqLineBuf (
    .iClk   (iClk),
    .iWe    (accept_s),
    .iAddr  (lbAddr_s),
    .iWData (sqInteg_s),
    .oRData (sqRData_s)
  );
`endif

  // sequencer FSM with registered handshake, status and pixel outputs
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_r    <= IDLE;
      rowAcc_r   <= '0;
      col_r      <= '0;
      row_r      <= '0;
      firstRow_r <= 1'b0;
      oData      <= '0;
      oRow       <= '0;
      oCol       <= '0;
      oValid     <= 1'b0;
      oDone      <= 1'b0;
      oReady     <= 1'b0;
      oBusy      <= 1'b0;
`ifdef IIG_SQ_EN
      sqAcc_r    <= '0;
      oSqData    <= '0;
`endif
    end else if (iAbort && (state_r != IDLE)) begin
      state_r <= IDLE;
      oValid  <= 1'b0;
      oDone   <= 1'b0;
      oReady  <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          oValid <= 1'b0;
          oDone  <= 1'b0;
          oReady <= 1'b0;
          if (iStart && !iAbort) begin
            state_r <= CLEAR;
            oBusy   <= 1'b1;
          end else begin
            oBusy   <= 1'b0;
          end
        end
        CLEAR: begin
          rowAcc_r   <= '0;
          col_r      <= '0;
          row_r      <= '0;
          firstRow_r <= 1'b1;
`ifdef IIG_SQ_EN
          sqAcc_r    <= '0;
`endif
          state_r    <= RUN;
          oReady     <= 1'b1;
          oBusy      <= 1'b1;
          oValid     <= 1'b0;
          oDone      <= 1'b0;
        end
        RUN: begin
          oValid <= accept_s;
          oDone  <= 1'b0;
          if (accept_s) begin
            rowAcc_r <= rowSum_s;
            oData    <= integ_s;
            oRow     <= row_r;
            oCol     <= col_r;
`ifdef IIG_SQ_EN
            sqAcc_r  <= sqSum_s;
            oSqData  <= sqInteg_s;
`endif
            if (col_r == CW'(WIN_W - 1)) begin
              oReady <= 1'b0;
              if (row_r == CW'(WIN_H - 1)) begin
                state_r <= DONE;
                oDone   <= 1'b1;
              end else begin
                state_r <= ROW_END;
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        ROW_END: begin
          rowAcc_r   <= '0;
`ifdef IIG_SQ_EN
          sqAcc_r    <= '0;
`endif
          col_r      <= '0;
          row_r      <= row_r + CW'(1);
          firstRow_r <= 1'b0;
          state_r    <= RUN;
          oReady     <= 1'b1;
          oValid     <= 1'b0;
          oDone      <= 1'b0;
        end
        DONE: begin
          state_r <= IDLE;
          oBusy   <= 1'b0;
          oReady  <= 1'b0;
          oValid  <= 1'b0;
          oDone   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          oBusy   <= 1'b0;
          oReady  <= 1'b0;
          oValid  <= 1'b0;
          oDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule
